// File: rtl/lattice_pkg.sv
// Shared definitions for the lattice readout and injector stages.
// Provides the cell width, direction bit positions, scan FSM state
// encoding and the helper that sizes the row particle counter.
package lattice_pkg;

  // Bits per cell state; one bit per particle direction.
  localparam int CW = 4;

  // Bit position of each direction inside a cell state.
  localparam int DIR_E = 0;
  localparam int DIR_N = 1;
  localparam int DIR_W = 2;
  localparam int DIR_S = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    SUM  = 2'd2
  } state_e;

  // Counter width that can hold every bit of a full row set at once.
  function automatic int cntw_f(input int ncells);
    return $clog2(ncells * CW + 1);
  endfunction

endpackage

// File: rtl/lattice_popcount.sv
// Combinational population count of one W-bit cell state.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake, output follows input.
// Ports: in_dat (W-bit state) -> cnt_dat (number of set bits).
module lattice_popcount
  import lattice_pkg::*;
#(
  parameter int  W  = CW,
  localparam int PW = $clog2(W + 1)
) (
  input  logic [W-1:0]  in_dat,
  output logic [PW-1:0] cnt_dat
);

  always_comb begin
    cnt_dat = '0;
    for (int i = 0; i < W; i++) begin
      cnt_dat = cnt_dat + PW'(in_dat[i]);
    end
  end

endmodule

// File: rtl/lattice_scan.sv
// Snapshot one row of lattice cells and stream it out one cell per beat,
// then pulse the row's total particle count.
// Latency: first beat 1 cycle after snap; sum 1 cycle after the last beat.
// Backpressure: out_ready low stalls the stream with all outputs held; the
// cell array is never stalled because the row is copied into a shadow.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   cells, snap      packed row input and capture request
//   out_valid/out_ready/out_data/out_idx/out_last   per-cell stream
//   sum_valid, sum_count   one-cycle pulse with the row population
//   busy, overrun, clr_ovr status, sticky lost-snap flag and its clear
module lattice_scan #(
  parameter int  NCELLS = 8,
  parameter int  CW     = lattice_pkg::CW,
  localparam int IDXW   = $clog2(NCELLS),
  localparam int CNTW   = lattice_pkg::cntw_f(NCELLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCELLS*CW-1:0] cells,
  input  logic                 snap,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW-1:0]        out_data,
  output logic [IDXW-1:0]      out_idx,
  output logic                 out_last,
  output logic                 sum_valid,
  output logic [CNTW-1:0]      sum_count,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_ovr
);

  import lattice_pkg::*;

  localparam int              PW       = $clog2(CW + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCELLS - 1);

  state_e               state_q,     state_d;
  logic [NCELLS*CW-1:0] shadow_q,    shadow_d;
  logic [IDXW-1:0]      idx_q,       idx_d;
  logic [CNTW-1:0]      acc_q,       acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [CW-1:0]        out_data_q,  out_data_d;
  logic                 out_last_q,  out_last_d;
  logic                 sum_valid_q, sum_valid_d;
  logic [CNTW-1:0]      sum_count_q, sum_count_d;
  logic                 busy_q,      busy_d;
  logic                 overrun_q,   overrun_d;

  logic [PW-1:0]        beat_pop;
  logic [CNTW-1:0]      acc_sum;
  logic [IDXW-1:0]      idx_inc;

  // Population of the beat currently on the output register.
  lattice_popcount #(
    .W (CW)
  ) u_popcount (
    .in_dat  (out_data_q),
    .cnt_dat (beat_pop)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    sum_valid_d = 1'b0;
    sum_count_d = sum_count_q;
    busy_d      = busy_q;
    overrun_d   = overrun_q;

    acc_sum = acc_q + CNTW'(beat_pop);
    idx_inc = idx_q + IDXW'(1);

    // A snap in SEND or SUM is lost; setting beats clearing.
    if (snap && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else if (clr_ovr) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (snap) begin
          state_d     = SEND;
          shadow_d    = cells;
          idx_d       = '0;
          acc_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = cells[CW-1:0];
          // The row has at least two cells, so beat 0 is never last.
          out_last_d  = 1'b0;
          busy_d      = 1'b1;
        end
      end

      SEND: begin
        // out_valid is always high here, so out_ready alone is the handshake.
        if (out_ready) begin
          acc_d = acc_sum;
          if (out_last_q) begin
            state_d     = SUM;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            sum_valid_d = 1'b1;
            sum_count_d = acc_sum;
          end else begin
            idx_d      = idx_inc;
            out_data_d = shadow_q[int'(idx_inc)*CW +: CW];
            out_last_d = (idx_inc == LAST_IDX);
          end
        end
      end

      SUM: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_count_q <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      sum_valid_q <= sum_valid_d;
      sum_count_q <= sum_count_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign sum_valid = sum_valid_q;
  assign sum_count = sum_count_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lattice_scan.sv
// Bench for lattice_scan: a 4-cell instance driven from a vector table with
// a beat/sum scoreboard, plus a few hand sequences and an 8-cell instance.
module tb_lattice_scan;

  logic clk;
  logic rst;

  // 4-cell instance
  logic [15:0] cells4;
  logic        snap4;
  logic        out_ready;
  logic        clr_ovr;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        sum_valid;
  logic [4:0]  sum_count;
  logic        busy;
  logic        overrun;

  // 8-cell instance
  logic [31:0] cells8;
  logic        snap8;
  logic        out_valid8;
  logic [3:0]  out_data8;
  logic [2:0]  out_idx8;
  logic        out_last8;
  logic        sum_valid8;
  logic [5:0]  sum_count8;
  logic        busy8;
  logic        overrun8;

  lattice_scan #(.NCELLS(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cells     (cells4),
    .snap      (snap4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .sum_valid (sum_valid),
    .sum_count (sum_count),
    .busy      (busy),
    .overrun   (overrun),
    .clr_ovr   (clr_ovr)
  );

  lattice_scan #(.NCELLS(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .cells     (cells8),
    .snap      (snap8),
    .out_valid (out_valid8),
    .out_ready (1'b1),
    .out_data  (out_data8),
    .out_idx   (out_idx8),
    .out_last  (out_last8),
    .sum_valid (sum_valid8),
    .sum_count (sum_count8),
    .busy      (busy8),
    .overrun   (overrun8),
    .clr_ovr   (1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_ctr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_ctr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc_ctr++;
  endtask

  // Scoreboard
  typedef struct packed {
    logic [3:0] data;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  beat_t      beat_q[$];
  logic [4:0] sum_q[$];

  task automatic push_row(input logic [15:0] c);
    for (int i = 0; i < 4; i++) begin
      beat_q.push_back(beat_t'({c[i*4 +: 4], 2'(i), (i == 3)}));
    end
  endtask

  // Monitor: evaluates at negedge what the next posedge will see.
  beat_t cur_beat;
  beat_t prev_beat;
  beat_t exp_beat;
  logic  prev_stall = 1'b0;
  int    hs_cnt = 0;
  int    first_beat_cyc = -1;
  int    sum_cyc = -1;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      cur_beat = {out_data, out_idx, out_last};
      if (out_valid && first_beat_cyc < 0) first_beat_cyc = cyc_ctr;
      if (prev_stall) begin
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        check("stall_beat_held", {25'd0, cur_beat}, {25'd0, prev_beat});
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (beat_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got beat %0h with no expected beat queued", cur_beat);
        end else begin
          exp_beat = beat_q.pop_front();
          check("beat", {25'd0, cur_beat}, {25'd0, exp_beat});
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur_beat;
      if (sum_valid) begin
        sum_cyc = cyc_ctr;
        if (sum_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_sum: got sum_valid with sum_count %0d, none expected", sum_count);
        end else begin
          check("sum_count", {27'd0, sum_count}, {27'd0, sum_q.pop_front()});
        end
      end
    end
  end

  // Vector table
  typedef struct {
    logic [15:0] cells;
    logic [15:0] pat;   // out_ready per cycle after snap, bit0 = cycle +1
    bit          chg;   // overwrite cells with FFFF right after capture
    logic [4:0]  sum;
    int          lat;   // expected snap->sum_valid cycles, 0 = unchecked
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string tag);
    int snap_cyc;
    int n;
    check({tag, "_idle_before"}, {31'd0, busy}, 32'd0);
    cells4 = v.cells;
    snap4  = 1'b1;
    push_row(v.cells);
    sum_q.push_back(v.sum);
    hs_cnt = 0;
    first_beat_cyc = -1;
    sum_cyc = -1;
    snap_cyc = cyc_ctr;
    tick();
    snap4 = 1'b0;
    out_ready = v.pat[0];
    if (v.chg) cells4 = 16'hFFFF;
    while (sum_cyc < 0 && (cyc_ctr - snap_cyc) < 40) begin
      tick();
      n = cyc_ctr - snap_cyc;
      out_ready = (n - 1 < 16) ? v.pat[n-1] : 1'b1;
    end
    out_ready = 1'b1;
    check({tag, "_sum_seen"}, {31'd0, (sum_cyc >= 0)}, 32'd1);
    check({tag, "_handshakes"}, hs_cnt, 32'd4);
    check({tag, "_first_beat_lat"}, first_beat_cyc - snap_cyc, 32'd1);
    if (v.lat != 0) check({tag, "_sum_lat"}, sum_cyc - snap_cyc, v.lat);
    check({tag, "_beats_left"}, beat_q.size(), 32'd0);
    check({tag, "_sums_left"}, sum_q.size(), 32'd0);
    beat_q.delete();
    sum_q.delete();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bit seen;

    vecs[0] = '{cells: 16'hF0A1, pat: 16'hFFFF, chg: 1'b0, sum: 5'd7,  lat: 5};
    vecs[1] = '{cells: 16'hF0A1, pat: 16'hFFE9, chg: 1'b0, sum: 5'd7,  lat: 8};
    vecs[2] = '{cells: 16'hF0A1, pat: 16'hFFFF, chg: 1'b1, sum: 5'd7,  lat: 5};
    vecs[3] = '{cells: 16'h1234, pat: 16'hFFFF, chg: 1'b0, sum: 5'd5,  lat: 5};
    vecs[4] = '{cells: 16'h0000, pat: 16'hFFF5, chg: 1'b0, sum: 5'd0,  lat: 0};
    vecs[5] = '{cells: 16'hFFFF, pat: 16'hFFFF, chg: 1'b0, sum: 5'd16, lat: 5};
    vecs[6] = '{cells: 16'h7EB3, pat: 16'hFF3F, chg: 1'b1, sum: 5'd11, lat: 0};

    rst = 1'b1;
    cells4 = 16'hFFFF;
    snap4 = 1'b0;
    out_ready = 1'b0;
    clr_ovr = 1'b0;
    cells8 = '1;
    snap8 = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {28'd0, out_data},  32'd0);
    check("rst_out_idx",   {30'd0, out_idx},   32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    check("rst_sum_valid", {31'd0, sum_valid}, 32'd0);
    check("rst_sum_count", {27'd0, sum_count}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_overrun",   {31'd0, overrun},   32'd0);
    check("rst8_sum_count", {26'd0, sum_count8}, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Snap during SEND: stream unaffected, overrun sticky until cleared.
    cells4 = 16'hF0A1;
    snap4 = 1'b1;
    push_row(16'hF0A1);
    sum_q.push_back(5'd7);
    sum_cyc = -1;
    tick();                       // cycle +1
    snap4 = 1'b0;
    tick();                       // cycle +2, beat 2 on the bus
    check("ovr_pre_snap", {31'd0, overrun}, 32'd0);
    snap4 = 1'b1;
    cells4 = 16'hFFFF;
    tick();                       // cycle +3
    snap4 = 1'b0;
    check("ovr_set_in_send", {31'd0, overrun}, 32'd1);
    check("ovr_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 10 && sum_cyc < 0; i++) tick();
    check("ovr_stream_sum_seen", {31'd0, (sum_cyc >= 0)}, 32'd1);
    tick();
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    check("ovr_beats_left", beat_q.size(), 32'd0);

    // clr_ovr with a lost snap: set wins. Then snap during SUM also sets it.
    cells4 = 16'hF0A1;
    snap4 = 1'b1;
    push_row(16'hF0A1);
    sum_q.push_back(5'd7);
    sum_cyc = -1;
    tick();                       // cycle +1
    snap4 = 1'b1;
    clr_ovr = 1'b1;
    tick();                       // cycle +2
    snap4 = 1'b0;
    clr_ovr = 1'b0;
    check("ovr_set_beats_clr", {31'd0, overrun}, 32'd1);
    clr_ovr = 1'b1;
    tick();                       // cycle +3
    clr_ovr = 1'b0;
    tick();                       // cycle +4
    check("ovr_clr_in_send", {31'd0, overrun}, 32'd0);
    tick();                       // cycle +5, SUM
    check("sum_cycle_pulse", {31'd0, sum_valid}, 32'd1);
    snap4 = 1'b1;
    cells4 = 16'h1234;
    tick();                       // back in IDLE
    snap4 = 1'b0;
    check("ovr_snap_in_sum", {31'd0, overrun}, 32'd1);
    check("snap_in_sum_busy", {31'd0, busy}, 32'd0);
    check("snap_in_sum_no_stream", {31'd0, out_valid}, 32'd0);
    check("sum_pulse_one_cycle", {31'd0, sum_valid}, 32'd0);
    check("sum_count_held", {27'd0, sum_count}, 32'd7);
    tick();
    check("snap_in_sum_still_idle", {31'd0, busy}, 32'd0);
    check("ovr2_beats_left", beat_q.size(), 32'd0);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;

    // Reset in the middle of the stream aborts it with no sum pulse.
    cells4 = 16'hF0A1;
    snap4 = 1'b1;
    push_row(16'hF0A1);
    sum_q.push_back(5'd7);
    tick();                       // cycle +1
    snap4 = 1'b0;
    tick();                       // cycle +2
    tick();                       // cycle +3, beat 3 on the bus
    check("pre_rst_idx", {30'd0, out_idx}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    beat_q.delete();
    sum_q.delete();
    sum_cyc = -1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_idx", {30'd0, out_idx}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    check("abort_no_sum", sum_cyc, 32'hFFFF_FFFF);
    run_vec(vecs[3], "post_rst");

    // 8-cell row, all particles set: sum needs the full counter width.
    snap8 = 1'b1;
    tick();
    snap8 = 1'b0;
    cells8 = '0;
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_valid8) begin
        check("n8_data", {28'd0, out_data8}, 32'hF);
        check("n8_idx", {29'd0, out_idx8}, k);
        check("n8_last", {31'd0, out_last8}, {31'd0, (k == 7)});
        k++;
      end
      if (sum_valid8) begin
        check("n8_sum", {26'd0, sum_count8}, 32'd32);
        seen = 1'b1;
      end
      if (!seen) tick();
    end
    check("n8_beats", k, 32'd8);
    check("n8_sum_seen", {31'd0, seen}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
